// File: rtl/counter_buf_ctrl.sv
// counter_buf_ctrl: pre/post-trigger circular capture into SRAM port A, oldest-relative reads on port B; decimation under COUNTER_BUF_DECIM_EN.
// Latency: port A write is combinational, read result 1 cycle after request; no backpressure, every sample/request is consumed.
module counter_buf_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_arm,
  input  logic                  i_stop,
  input  logic                  i_trigger,
  input  logic [ADDR_WIDTH:0]   i_post_len,
  input  logic [15:0]           i_decim,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic [ADDR_WIDTH-1:0] o_sram_addr_a,
  output logic                  o_sram_we_a,
  output logic [DATA_WIDTH-1:0] o_sram_data_a,
  output logic [ADDR_WIDTH-1:0] o_sram_addr_b,
  output logic                  o_sram_we_b,
  input  logic [DATA_WIDTH-1:0] i_sram_data_b,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx,
  output logic                  o_rd_valid,
  output logic                  o_rd_err,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [1:0]            o_state,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_fill,
  output logic [ADDR_WIDTH-1:0] o_trig_ptr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PRE  = 2'd1;
  localparam logic [1:0] S_POST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [ADDR_WIDTH:0] DEPTH_F = (ADDR_WIDTH+1)'(DEPTH);

  logic [1:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr, trig_ptr, oldest;
  logic [ADDR_WIDTH:0]   fill, remaining, post_len_sat;
  logic                  wrapped;
  logic                  capturing, restart, trig_evt, zero_trig, cmd_block;
  logic                  accept, we_a;
  logic                  rd_valid, rd_err;

  assign capturing    = (state == S_PRE) || (state == S_POST);
  assign restart      = i_arm & ~i_stop;
  assign trig_evt     = (state == S_PRE) & i_trigger & ~i_stop & ~i_arm;
  assign zero_trig    = trig_evt & (i_post_len == '0);
  // Command cycles that abort, restart or end capture with zero length never write.
  assign cmd_block    = i_stop | i_arm | zero_trig;
  assign post_len_sat = (i_post_len > DEPTH_F) ? DEPTH_F : i_post_len;

`ifdef COUNTER_BUF_DECIM_EN
  logic [15:0] dec_cnt;
  logic        dec_step;

  assign dec_step = i_sample_valid & capturing & ~cmd_block;
  assign accept   = (dec_cnt == 16'd0);

  // Phase survives the trigger; only arm realigns it so the first sample is taken.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)       dec_cnt <= 16'd0;
    else if (restart)  dec_cnt <= 16'd0;
    else if (dec_step) dec_cnt <= (dec_cnt >= i_decim) ? 16'd0 : dec_cnt + 16'd1;
  end
`else
  logic unused_decim;
  assign unused_decim = ^i_decim;
  assign accept       = 1'b1;
`endif

  assign we_a = i_sample_valid & capturing & ~cmd_block & accept;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (i_stop) begin
      state_nxt = S_IDLE;
    end else if (i_arm) begin
      state_nxt = S_PRE;
    end else begin
      case (state)
        S_PRE: begin
          if (i_trigger) begin
            if (i_post_len == '0)
              state_nxt = S_DONE;
            else if (we_a && post_len_sat == (ADDR_WIDTH+1)'(1))
              state_nxt = S_DONE;
            else
              state_nxt = S_POST;
          end
        end
        S_POST: begin
          if (we_a && remaining == (ADDR_WIDTH+1)'(1)) state_nxt = S_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    o_state = state;
    o_done  = (state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr    <= '0;
      fill      <= '0;
      wrapped   <= 1'b0;
      remaining <= '0;
      trig_ptr  <= '0;
    end else if (restart) begin
      wr_ptr  <= '0;
      fill    <= '0;
      wrapped <= 1'b0;
    end else begin
      if (we_a) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        if (fill != DEPTH_F) fill <= fill + (ADDR_WIDTH+1)'(1);
        if (wr_ptr == '1)    wrapped <= 1'b1;
      end
      // The trigger-cycle write is the first post-trigger sample and counts immediately.
      if (trig_evt) begin
        trig_ptr  <= wr_ptr;
        remaining <= post_len_sat - (ADDR_WIDTH+1)'(we_a);
      end else if (state == S_POST && we_a) begin
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  assign oldest        = wrapped ? wr_ptr : '0;
  assign o_sram_addr_b = oldest + i_rd_idx;
  assign o_sram_we_b   = 1'b0;
  assign o_sram_addr_a = wr_ptr;
  assign o_sram_we_a   = we_a;
  assign o_sram_data_a = i_sample;
  assign o_fill        = fill;
  assign o_trig_ptr    = trig_ptr;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= i_rd_req;
      rd_err   <= i_rd_req & ({1'b0, i_rd_idx} >= fill);
    end
  end

  assign o_rd_valid = rd_valid;
  assign o_rd_err   = rd_err;
  assign o_rd_data  = (rd_valid && !rd_err) ? i_sram_data_b : '0;

endmodule

// File: tb/tb_counter_buf_ctrl.sv
// Bench for counter_buf_ctrl at DEPTH=16: directed scenarios plus random traffic against a queue-based buffer model.
module tb_counter_buf_ctrl;
  localparam int AW = 4;
  localparam int DW = 18;
  localparam int DEPTH = 16;

  logic          i_clk = 1'b0;
  logic          i_rstn;
  logic          i_arm, i_stop, i_trigger, i_sample_valid, i_rd_req;
  logic [AW:0]   i_post_len;
  logic [15:0]   i_decim;
  logic [DW-1:0] i_sample;
  logic [AW-1:0] o_sram_addr_a, o_sram_addr_b, i_rd_idx, o_trig_ptr;
  logic          o_sram_we_a, o_sram_we_b, o_rd_valid, o_rd_err, o_done;
  logic [DW-1:0] o_sram_data_a, o_rd_data, sram_q;
  logic [1:0]    o_state;
  logic [AW:0]   o_fill;

  counter_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_arm(i_arm), .i_stop(i_stop), .i_trigger(i_trigger),
    .i_post_len(i_post_len), .i_decim(i_decim), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
    .o_sram_addr_a(o_sram_addr_a), .o_sram_we_a(o_sram_we_a), .o_sram_data_a(o_sram_data_a),
    .o_sram_addr_b(o_sram_addr_b), .o_sram_we_b(o_sram_we_b), .i_sram_data_b(sram_q),
    .i_rd_req(i_rd_req), .i_rd_idx(i_rd_idx), .o_rd_valid(o_rd_valid), .o_rd_err(o_rd_err),
    .o_rd_data(o_rd_data), .o_state(o_state), .o_done(o_done), .o_fill(o_fill), .o_trig_ptr(o_trig_ptr)
  );

  always #5 i_clk = ~i_clk;

  // Dual-port SRAM, 1-cycle read; port A wins a same-address collision.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge i_clk) begin
    if (o_sram_we_a) mem[o_sram_addr_a] <= o_sram_data_a;
    sram_q <= (o_sram_we_a && o_sram_addr_a == o_sram_addr_b) ? o_sram_data_a : mem[o_sram_addr_b];
  end

  typedef struct { int stamp; logic err; logic [DW-1:0] data; } rexp_t;
  typedef struct { int addr; logic [DW-1:0] data; } wexp_t;
  rexp_t rq_q[$];
  wexp_t wq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int g_decim = 0;

  // Reference model: state, count of writes since arm, and the retained samples oldest-first.
  int m_state, m_n, m_rem, m_trig, m_vcnt;
  logic [DW-1:0] m_buf[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_state = 0; m_n = 0; m_rem = 0; m_trig = 0; m_vcnt = 0;
    m_buf.delete();
    rq_q.delete();
    wq.delete();
  endtask

  task automatic tick(input logic arm, input logic stop, input logic trig, input int pl,
                      input logic sv, input logic [DW-1:0] smp, input logic rq, input int idx);
    int fill, wptr;
    bit wrapped, capt, blk, acc, we;
    rexp_t re;
    wexp_t wx;
    @(negedge i_clk);
    cyc++;
    i_arm = arm; i_stop = stop; i_trigger = trig; i_post_len = (AW+1)'(pl);
    i_sample_valid = sv; i_sample = smp; i_rd_req = rq; i_rd_idx = AW'(idx);
    i_decim = 16'(g_decim);
    #1;
    fill    = (m_n > DEPTH) ? DEPTH : m_n;
    wrapped = (m_n >= DEPTH);
    wptr    = m_n % DEPTH;
    check("state", 32'(o_state), m_state);
    check("done", 32'(o_done), 32'(m_state == 3));
    check("fill", 32'(o_fill), fill);
    check("trig_ptr", 32'(o_trig_ptr), m_trig);
    check("we_b", 32'(o_sram_we_b), 0);
    capt = (m_state == 1 || m_state == 2);
    blk  = stop || arm || (m_state == 1 && trig && pl == 0);
`ifdef COUNTER_BUF_DECIM_EN
    acc = (m_vcnt % (g_decim + 1)) == 0;
`else
    acc = 1'b1;
`endif
    we = sv && capt && !blk && acc;
    if (sv && capt && !blk) m_vcnt++;
    if (rq) begin
      re.stamp = cyc;
      re.err = (idx >= fill);
      if (re.err) re.data = '0;
      else if (we && wrapped && idx == 0) re.data = smp;
      else re.data = m_buf[idx];
      rq_q.push_back(re);
    end
    if (we) begin
      wx.addr = wptr; wx.data = smp;
      wq.push_back(wx);
      m_buf.push_back(smp);
      if (m_buf.size() > DEPTH) void'(m_buf.pop_front());
      m_n++;
    end
    if (stop) m_state = 0;
    else if (arm) begin
      m_state = 1; m_n = 0; m_vcnt = 0;
      m_buf.delete();
    end else if (m_state == 1 && trig) begin
      m_trig = wptr;
      if (pl == 0) m_state = 3;
      else begin
        m_rem = ((pl > DEPTH) ? DEPTH : pl) - (we ? 1 : 0);
        m_state = (m_rem == 0) ? 3 : 2;
      end
    end else if (m_state == 2 && we) begin
      m_rem--;
      if (m_rem == 0) m_state = 3;
    end
  endtask

  task automatic idle();                           tick(0, 0, 0, 0, 0, '0, 0, 0); endtask
  task automatic do_arm();                         tick(1, 0, 0, 0, 0, '0, 0, 0); endtask
  task automatic smp(input logic [DW-1:0] v);      tick(0, 0, 0, 0, 1, v, 0, 0); endtask
  task automatic trig(input int pl);               tick(0, 0, 1, pl, 0, '0, 0, 0); endtask
  task automatic rd(input int idx);                tick(0, 0, 0, 0, 0, '0, 1, idx); endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    model_clear();
    i_arm = 0; i_stop = 0; i_trigger = 0; i_sample_valid = 0; i_rd_req = 0;
    #1;
    check("rst_state", 32'(o_state), 0);
    check("rst_fill", 32'(o_fill), 0);
    check("rst_rd_valid", 32'(o_rd_valid), 0);
    check("rst_trig_ptr", 32'(o_trig_ptr), 0);
    check("rst_we_a", 32'(o_sram_we_a), 0);
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a read result.
  initial begin
    wexp_t w;
    rexp_t r;
    bit exp_v;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_rstn === 1'b1) begin
        check("sram_we_a", 32'(o_sram_we_a), 32'(wq.size() > 0));
        if (wq.size() > 0) begin
          w = wq.pop_front();
          if (o_sram_we_a) begin
            check("sram_addr_a", 32'(o_sram_addr_a), w.addr);
            check("sram_data_a", 32'(o_sram_data_a), 32'(w.data));
          end
        end
        exp_v = (rq_q.size() > 0) && (rq_q[0].stamp < cyc);
        check("rd_valid", 32'(o_rd_valid), 32'(exp_v));
        if (exp_v) begin
          r = rq_q.pop_front();
          if (o_rd_valid) begin
            check("rd_err", 32'(o_rd_err), 32'(r.err));
            check("rd_data", 32'(o_rd_data), 32'(r.data));
          end
        end
      end
    end
  end

  initial begin
    int r;
    logic a, s, t, sv, rq;
    i_rstn = 1'b0;
    i_arm = 0; i_stop = 0; i_trigger = 0; i_post_len = '0; i_decim = '0;
    i_sample_valid = 0; i_sample = '0; i_rd_req = 0; i_rd_idx = '0;
    model_clear();
    #12;
    check("init_state", 32'(o_state), 0);
    check("init_done", 32'(o_done), 0);
    check("init_rd_err", 32'(o_rd_err), 0);
    check("init_rd_data", 32'(o_rd_data), 0);
    do_reset();

    // Short post-trigger window: capture stops after the third post sample.
    do_arm();
    for (int i = 1; i <= 5; i++) smp(DW'(i));
    trig(3);
    for (int i = 6; i <= 10; i++) smp(DW'(i));
    idle();
    check("t1_state", 32'(o_state), 3);
    check("t1_fill", 32'(o_fill), 8);
    check("t1_trig_ptr", 32'(o_trig_ptr), 5);

    // Wrap-around: oldest moves to wr_ptr.
    do_arm();
    for (int i = 1; i <= 20; i++) smp(DW'(i));
    trig(4);
    for (int i = 21; i <= 24; i++) smp(DW'(i));
    idle();
    check("t2_fill", 32'(o_fill), 16);
    check("t2_addr_a", 32'(o_sram_addr_a), 8);
    rd(0);
    idle();
    check("t2_rd0", 32'(o_rd_data), 9);
    rd(15);
    idle();
    check("t2_rd15", 32'(o_rd_data), 24);

    // Zero-length post window with a coincident sample.
    do_arm();
    for (int i = 1; i <= 3; i++) smp(DW'(i + 100));
    tick(0, 0, 1, 0, 1, DW'(99), 0, 0);
    idle();
    check("t3_state", 32'(o_state), 3);
    check("t3_trig_ptr", 32'(o_trig_ptr), 3);
    check("t3_fill", 32'(o_fill), 3);

    // Back-to-back reads straddling the fill boundary.
    do_arm();
    for (int i = 1; i <= 8; i++) smp(DW'(i));
    tick(0, 1, 0, 0, 0, '0, 0, 0);
    rd(7);
    rd(8);
    check("t4_data7", 32'(o_rd_data), 8);
    check("t4_err7", 32'(o_rd_err), 0);
    idle();
    check("t4_err8", 32'(o_rd_err), 1);
    check("t4_data8", 32'(o_rd_data), 0);

    // Stop beats arm; arm beats trigger.
    do_arm();
    smp(DW'(1)); smp(DW'(2));
    trig(5);
    smp(DW'(3));
    tick(1, 1, 0, 0, 1, DW'(4), 0, 0);
    idle();
    check("t5_state_stop", 32'(o_state), 0);
    check("t5_fill_kept", 32'(o_fill), 3);
    tick(1, 0, 1, 3, 0, '0, 0, 0);
    idle();
    check("t5_state_arm", 32'(o_state), 1);

`ifdef COUNTER_BUF_DECIM_EN
    g_decim = 2;
    do_reset();
    do_arm();
    for (int i = 1; i <= 9; i++) smp(DW'(i));
    idle();
    check("t6_fill", 32'(o_fill), 3);
    rd(0); rd(1); rd(2);
    idle();
    g_decim = 1;
`endif

    // Randomised traffic, with periodic mid-capture resets dropping an in-flight read.
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      if (n % 800 == 799) begin
        rd($urandom_range(0, 15));
        do_reset();
      end else begin
        r  = $urandom_range(0, 99);
        a  = (r < 3) || (m_state == 3 && $urandom_range(0, 9) == 0) || (m_state == 0 && $urandom_range(0, 19) == 0);
        s  = (r >= 3 && r < 5);
        t  = ($urandom_range(0, 99) < 6);
        sv = ($urandom_range(0, 9) < 7);
        rq = ($urandom_range(0, 2) == 0);
        tick(a, s, t, $urandom_range(0, 20), sv, DW'($urandom), rq, $urandom_range(0, 15));
      end
    end
    idle();
    idle();
    idle();
    check("end_rq_empty", 32'(rq_q.size()), 0);
    check("end_wq_empty", 32'(wq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
